// File: rtl/text_overlay_pkg.sv
// Shared definitions for the character-cell text overlay: font geometry,
// the blank/space code, clear FSM states and the cell index helper.
package text_overlay_pkg;

    localparam int         FONT_W     = 8;
    localparam int         FONT_H     = 8;
    localparam logic [7:0] SPACE_CODE = 8'h20;

    typedef enum logic {
        IDLE,
        CLEAR
    } clr_state_e;

    function automatic int cell_index(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/text_overlay_charbuf.sv
// Simple dual-port character buffer: one write port, one registered read port.
// A same-cycle read of the address being written returns the old contents.
module text_overlay_charbuf #(
    parameter int DEPTH = 896,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/text_overlay.sv
// Character-cell overlay renderer: maps the raster onto the char buffer and font
// RAM and emits a 1-bit overlay pixel three cycles after each x/y.
module text_overlay
    import text_overlay_pkg::*;
#(
    parameter int          COLS         = 32,
    parameter int          ROWS         = 28,
    parameter int          X0           = 0,
    parameter int          Y0           = 0,
    parameter logic [10:0] FONT_BASE    = 11'h400,
    parameter int          BLINK_FRAMES = 16,
    localparam int         AW           = $clog2(COLS * ROWS),
    localparam int         RW           = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          clr,
    output logic          busy,
    input  logic [RW-1:0] scroll,
    input  logic          cur_en,
    input  logic [AW-1:0] cur_addr,
    input  logic          frame_start,
    input  logic          pix_valid,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    output logic [10:0]   font_addr,
    input  logic [7:0]    font_data,
    output logic          ov_valid,
    output logic          ov_on,
    output logic          ov_pix
);

    localparam int            CS        = $clog2(FONT_W);
    localparam int            LS        = $clog2(FONT_H);
    localparam int            SW        = 12 - LS;
    localparam int            FW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [AW-1:0] LAST_CELL = AW'(COLS * ROWS - 1);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic          busy_q, busy_d;
    logic [RW-1:0] scroll_q, scroll_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          blink_q, blink_d;
    logic          live_q, live_d;

    logic          s1_valid_q, s1_valid_d;
    logic          s1_on_q, s1_on_d;
    logic          s1_cur_q, s1_cur_d;
    logic [CS-1:0] s1_xb_q, s1_xb_d;
    logic [LS-1:0] s1_line_q, s1_line_d;

    logic          s2_valid_q, s2_valid_d;
    logic          s2_on_q, s2_on_d;
    logic          s2_inv_q, s2_inv_d;
    logic          s2_cur_q, s2_cur_d;
    logic [CS-1:0] s2_xb_q, s2_xb_d;

    logic          ov_valid_q, ov_valid_d;
    logic          ov_on_q, ov_on_d;
    logic          ov_pix_q, ov_pix_d;

    logic [10:0]    dx, dy;
    logic [10-CS:0] col;
    logic [10-LS:0] row;
    logic [SW-1:0]  row_sum, buf_row;
    logic           in_win;
    logic [AW-1:0]  rd_addr, screen_cell;
    logic [7:0]     code;
    logic [10:0]    glyph_addr;

    logic           ram_we;
    logic [AW-1:0]  ram_waddr;
    logic [7:0]     ram_wdata;

    text_overlay_charbuf #(
        .DEPTH(COLS * ROWS),
        .AW   (AW)
    ) u_charbuf (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(rd_addr),
        .rdata(code)
    );

    // Clear sweep owns the write port while active; CPU writes are dropped then.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                if (clr_addr_q == LAST_CELL) begin
                    state_d = IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d    = (state_d == CLEAR);
        ram_we    = (state_q == CLEAR) || wr_en;
        ram_waddr = (state_q == CLEAR) ? clr_addr_q : wr_addr;
        ram_wdata = (state_q == CLEAR) ? SPACE_CODE : wr_data;

        scroll_d = scroll_q;
        frame_d  = frame_q;
        blink_d  = blink_q;
        if (frame_start) begin
            if (int'(scroll) < ROWS) begin
                scroll_d = scroll;
            end
            if (int'(frame_q) == BLINK_FRAMES - 1) begin
                frame_d = '0;
                blink_d = ~blink_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    // Stage N: window test, scrolled buffer address and cursor match.
    always_comb begin
        dx      = {1'b0, x} - 11'(X0);
        dy      = {1'b0, y} - 11'(Y0);
        col     = dx[10:CS];
        row     = dy[10:LS];
        in_win  = !dx[10] && !dy[10] && (int'(col) < COLS) && (int'(row) < ROWS);
        row_sum = SW'(row) + SW'(scroll_q);
        buf_row = (int'(row_sum) >= ROWS) ? row_sum - SW'(ROWS) : row_sum;

        screen_cell = AW'(cell_index(int'(row), int'(col), COLS));
        rd_addr     = in_win ? AW'(cell_index(int'(buf_row), int'(col), COLS)) : '0;

        s1_valid_d = pix_valid;
        s1_on_d    = in_win;
        s1_cur_d   = in_win && cur_en && (screen_cell == cur_addr);
        s1_xb_d    = dx[CS-1:0];
        s1_line_d  = dy[LS-1:0];
        live_d     = 1'b1;
    end

    // Stage N+1: control codes fetch the space glyph's first row, so they render blank.
    always_comb begin
        if (code[6:0] < SPACE_CODE[6:0]) begin
            glyph_addr = FONT_BASE + {SPACE_CODE, 3'b000};
        end else begin
            glyph_addr = FONT_BASE + {1'b0, code[6:0], s1_line_q};
        end
        font_addr = live_q ? glyph_addr : '0;

        s2_valid_d = s1_valid_q;
        s2_on_d    = s1_on_q;
        s2_inv_d   = code[7];
        s2_cur_d   = s1_cur_q;
        s2_xb_d    = s1_xb_q;

        ov_valid_d = s2_valid_q;
        ov_on_d    = s2_on_q;
        ov_pix_d   = s2_on_q & (font_data[s2_xb_q] ^ s2_inv_q ^ (s2_cur_q & blink_q));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            clr_addr_q <= '0;
            busy_q     <= 1'b0;
            scroll_q   <= '0;
            frame_q    <= '0;
            blink_q    <= 1'b0;
            live_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_on_q    <= 1'b0;
            s1_cur_q   <= 1'b0;
            s1_xb_q    <= '0;
            s1_line_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_on_q    <= 1'b0;
            s2_inv_q   <= 1'b0;
            s2_cur_q   <= 1'b0;
            s2_xb_q    <= '0;
            ov_valid_q <= 1'b0;
            ov_on_q    <= 1'b0;
            ov_pix_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            busy_q     <= busy_d;
            scroll_q   <= scroll_d;
            frame_q    <= frame_d;
            blink_q    <= blink_d;
            live_q     <= live_d;
            s1_valid_q <= s1_valid_d;
            s1_on_q    <= s1_on_d;
            s1_cur_q   <= s1_cur_d;
            s1_xb_q    <= s1_xb_d;
            s1_line_q  <= s1_line_d;
            s2_valid_q <= s2_valid_d;
            s2_on_q    <= s2_on_d;
            s2_inv_q   <= s2_inv_d;
            s2_cur_q   <= s2_cur_d;
            s2_xb_q    <= s2_xb_d;
            ov_valid_q <= ov_valid_d;
            ov_on_q    <= ov_on_d;
            ov_pix_q   <= ov_pix_d;
        end
    end

    assign busy     = busy_q;
    assign ov_valid = ov_valid_q;
    assign ov_on    = ov_on_q;
    assign ov_pix   = ov_pix_q;

endmodule

// File: doc/text_overlay.md
# text_overlay

Parametrised character-cell overlay renderer for the on-screen menu. It holds a COLS×ROWS character buffer written by the iosys CPU and walks the live video raster. For each pixel it fetches the 8×8 glyph row from the shared font RAM (port B of the menu DPB) and emits a 1-bit overlay pixel. It adds row scrolling, an inverse-video attribute, a blinking cursor and a hardware clear, none of which the plain font RAM provides.

## Interface
Parameters:
- COLS, 32, character columns
- ROWS, 28, character rows
- X0, 0, first raster x of the text window
- Y0, 0, first raster y of the text window
- FONT_BASE, 11'h400, font RAM base; glyph row address = FONT_BASE + code*8 + line
- BLINK_FRAMES, 16, frames per cursor blink half-period

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low (`clk`, `resetn`).
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- wr_en  in  1  character buffer write strobe
- wr_addr  in  AW=$clog2(COLS*ROWS)  cell index, row*COLS+col
- wr_data  in  8  [6:0] ASCII code, [7] inverse attribute
- clr  in  1  pulse: fill the buffer with 0x20
- busy  out  1  clear in progress
- scroll  in  RW=$clog2(ROWS)  first buffer row shown on screen
- cur_en  in  1  cursor enable
- cur_addr  in  AW  cursor cell index
- frame_start  in  1  one-cycle pulse at the start of each frame
- pix_valid  in  1  x/y qualify the current pixel
- x, y  in  10 each  raster coordinates
- font_addr  out  11  font RAM address, synchronous read, 1-cycle latency
- font_data  in  8  glyph row; bit 0 is the leftmost pixel
- ov_valid  out  1  delayed pix_valid
- ov_on  out  1  pixel lies inside the text window
- ov_pix  out  1  foreground pixel

## Operation
- Char buffer: internal COLS*ROWS×8 sync RAM with one write and one read port. A same-cycle write and read to the same address returns the old data. Contents are undefined after reset until a clear completes.
- Clear FSM, IDLE→CLEAR on clr while IDLE:
  - Writes 0x20 to addresses 0..COLS*ROWS-1, one per cycle.
  - busy=1 throughout; the FSM returns to IDLE after the last address.
  - wr_en is ignored while busy. clr while busy is ignored.
- Window: col=(x-X0)>>3, row=(y-Y0)>>3. The pixel is inside when x≥X0, y≥Y0, col<COLS and row<ROWS. Compute in 11-bit signed to catch x<X0.
- Scroll:
  - buf_row = row+scroll, minus ROWS if the sum is ≥ROWS (single conditional subtract).
  - scroll is sampled into scroll_q only on frame_start. A sampled value ≥ROWS is discarded and scroll_q is held.
- Glyph:
  - code[6:0]<0x20 renders blank: font_addr is forced to FONT_BASE+0x100 (the space glyph).
  - Otherwise font_addr = FONT_BASE + {code[6:0], line[2:0]}, where line=(y-Y0)[2:0]. Truncate to 11 bits.
- Pixel: bit = font_data[(x-X0)[2:0]]; ov_pix = ov_on & (bit ^ code[7] ^ (cur_en & cell==cur_addr & blink)). The cursor compares the screen cell (pre-scroll index row*COLS+col) with cur_addr.
- Blink: frame counter 0..BLINK_FRAMES-1 increments on frame_start. On wrap, blink toggles.

## Timing
- Pipeline, with x/y presented at cycle N:
  - N: window and cell address computed; char buffer read issued.
  - N+1: code returned; font_addr registered.
  - N+2: font_data valid.
  - N+3: ov_valid/ov_on/ov_pix registered.
- Fixed latency of 3. The pipeline free-runs; pix_valid only rides along with the data.
- Outside the window, ov_on=0 and ov_pix=0, whatever the font data.
- Reset values: ov_valid=0, ov_on=0, ov_pix=0, font_addr=0, busy=0, FSM=IDLE, blink=0, frame counter=0, scroll_q=0.
- Reset asserted mid-clear aborts the clear. The buffer keeps its partial contents.

## Structure
- Shared overlay package holds:
  - FONT_W=8 and FONT_H=8
  - SPACE_CODE=8'h20
  - the clear FSM state enum {IDLE, CLEAR}
  - a function computing cell index from row/col
- One sub-module, text_overlay_charbuf: the inferred simple dual-port char RAM. Everything else lives at top level.

## Test plan
- Cell write and glyph fetch:
  - Stimulus: font model preloaded; write 0x41 to cell 0; scroll=0; raster x=0..7, y=0.
  - Required response: font_addr=0x608 seen at N+1; ov_pix=1 only at x=2,3 (row byte 0x0C), 3 cycles after x.
- Inverse attribute: write 0xC1 to cell 0 → same row renders ~0x0C; x=0 gives ov_pix=1.
- Scroll wrap:
  - Setup: ROWS=28; write 'B' to cell 27*COLS; scroll=27 latched at frame_start.
  - Required response: screen row 0 shows 'B'.
  - Then drive scroll=30 → ignored, and screen row 0 still shows 'B'.
- Clear:
  - Stimulus: pulse clr; hold wr_en=1 to cell 5 during clear.
  - Required response: busy high exactly COLS*ROWS cycles; afterwards every cell reads 0x20; the cell-5 write is lost.
- Cursor blink:
  - Setup: BLINK_FRAMES=2, cur_en=1, cur_addr=0, cell 0=0x20.
  - Required response: ov_pix toggles all-on/all-off every 2 frame_start pulses.
- Window bounds and reset: X0=16; x=15 and x=16+COLS*8 give ov_on=0; resetn low mid-frame → all outputs 0 next cycle.
